// File: rtl/spi_master_if.sv
// Control-bus register interface shared by the SPI peripherals: CPU access plus completion interrupt.
interface spi_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] address;
  logic              we;
  logic              sel;
  logic              interrupt;

  modport master (output data_in, address, we, sel, input data_out, interrupt);
  modport slave  (input data_in, address, we, sel, output data_out, interrupt);
endinterface

// File: rtl/spi_master.sv
// SPI master behind the control-bus registers: each SPI_TX write runs one full-duplex LSB-first word;
// the result appears at SPI_RX and completion is flagged by READY plus a one-cycle interrupt.
module spi_master #(
  parameter int                CLK_DIV   = 4,
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 4,
  parameter logic [ADDR_W-1:0] SPI_READY = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] SPI_TX    = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] SPI_RX    = ADDR_W'(2)
) (
  input  logic        clk,
  input  logic        rst,
  output logic        sclk,
  output logic        ss,
  output logic        mosi,
  input  logic        miso,
  spi_master_if.slave bus
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(DATA_W - 1);
  localparam logic [5:0] BIT_DONE = 6'(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_PRE_H, S_PRE_L, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t            r_state, w_state;
  logic              r_sclk, w_sclk, r_ss, w_ss, r_mosi, w_mosi;
  logic [7:0]        r_div, w_div;
  logic [5:0]        r_bit, w_bit;
  logic              r_gap2, w_gap2;
  logic [DATA_W-1:0] r_tx_sr, w_tx_sr, r_rx_sr, w_rx_sr, r_rx_data, w_rx_data;
  logic              r_ready, w_ready, r_irq, w_irq;
  logic              w_start, w_phase_end, w_raise;

  assign w_start     = bus.sel & bus.we & (bus.address == SPI_TX) & r_ready;
  assign w_phase_end = (r_div == DIV_LAST);

  always_comb begin
    w_state   = r_state;
    w_sclk    = r_sclk;
    w_ss      = r_ss;
    w_mosi    = r_mosi;
    w_bit     = r_bit;
    w_gap2    = r_gap2;
    w_tx_sr   = r_tx_sr;
    w_rx_sr   = r_rx_sr;
    w_rx_data = r_rx_data;
    w_ready   = r_ready;
    w_irq     = 1'b0;
    w_raise   = 1'b0;
    w_div     = (r_state == S_IDLE || w_phase_end) ? 8'd0 : r_div + 8'd1;
    case (r_state)
      S_IDLE: if (w_start) begin
        w_state = S_PRE_H;
        w_sclk  = 1'b1;
        w_ready = 1'b0;
        w_tx_sr = bus.data_in;
        w_bit   = '0;
      end
      // The falling edge into PRE_L, with ss still high, is what preloads the slave's TX word
      S_PRE_H: if (w_phase_end) begin
        w_state = S_PRE_L;
        w_sclk  = 1'b0;
      end
      S_PRE_L: if (w_phase_end) begin
        w_state = S_SETUP;
        w_ss    = 1'b0;
        w_mosi  = r_tx_sr[0];
      end
      S_SETUP: if (w_phase_end) begin
        w_state = S_SHIFT;
        w_raise = 1'b1;
      end
      S_SHIFT: if (w_phase_end) begin
        if (r_sclk) begin
          w_sclk = 1'b0;
          w_bit  = r_bit + 6'd1;
        end else if (r_bit == BIT_DONE) begin
          w_state = S_HOLD;
        end else begin
          w_raise = 1'b1;
        end
      end
      S_HOLD: if (w_phase_end) begin
        w_state = S_GAP;
        w_ss    = 1'b1;
        w_mosi  = 1'b0;
        w_gap2  = 1'b0;
      end
      // Two phases of ss high so the slave's ss resampler reliably sees the deselect
      S_GAP: if (w_phase_end) begin
        if (!r_gap2) begin
          w_gap2 = 1'b1;
        end else begin
          w_state   = S_IDLE;
          w_rx_data = r_rx_sr;
          w_ready   = 1'b1;
          w_irq     = 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_sclk  = 1'b0;
        w_ss    = 1'b1;
        w_mosi  = 1'b0;
        w_ready = 1'b1;
      end
    endcase
    // Rising sclk: sample miso, and present the next tx bit so it is stable over the following fall
    if (w_raise) begin
      w_sclk  = 1'b1;
      w_rx_sr = {miso, r_rx_sr[DATA_W-1:1]};
      if (r_bit != BIT_LAST) begin
        w_tx_sr = r_tx_sr >> 1;
        w_mosi  = r_tx_sr[1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_sclk    <= 1'b0;
      r_ss      <= 1'b1;
      r_mosi    <= 1'b0;
      r_div     <= '0;
      r_bit     <= '0;
      r_gap2    <= 1'b0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_rx_data <= '0;
      r_ready   <= 1'b1;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_sclk    <= w_sclk;
      r_ss      <= w_ss;
      r_mosi    <= w_mosi;
      r_div     <= w_div;
      r_bit     <= w_bit;
      r_gap2    <= w_gap2;
      r_tx_sr   <= w_tx_sr;
      r_rx_sr   <= w_rx_sr;
      r_rx_data <= w_rx_data;
      r_ready   <= w_ready;
      r_irq     <= w_irq;
    end
  end

  always_comb begin
    bus.data_out = '0;
    if (bus.address == SPI_READY)   bus.data_out = {{(DATA_W-1){1'b0}}, r_ready};
    else if (bus.address == SPI_RX) bus.data_out = r_rx_data;
  end

  assign bus.interrupt = r_irq;
  assign sclk          = r_sclk;
  assign ss            = r_ss;
  assign mosi          = r_mosi;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: two instances (CLK_DIV=4 and CLK_DIV=1) plus a behavioural SPI slave.
module tb_spi_master;
  localparam logic [3:0] A_READY = 4'd0;
  localparam logic [3:0] A_TX    = 4'd1;
  localparam logic [3:0] A_RX    = 4'd2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_if #(.DATA_W(32), .ADDR_W(4)) bus4 ();
  spi_master_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();

  logic sclk4, ss4, mosi4, miso4;
  logic sclk1, ss1, mosi1;
  logic use_slave = 1'b0;

  spi_master #(.CLK_DIV(4), .DATA_W(32), .ADDR_W(4),
               .SPI_READY(A_READY), .SPI_TX(A_TX), .SPI_RX(A_RX)) u_dut4 (
    .clk(clk), .rst(rst), .sclk(sclk4), .ss(ss4), .mosi(mosi4), .miso(miso4), .bus(bus4));

  spi_master #(.CLK_DIV(1), .DATA_W(32), .ADDR_W(4),
               .SPI_READY(A_READY), .SPI_TX(A_TX), .SPI_RX(A_RX)) u_dut1 (
    .clk(clk), .rst(rst), .sclk(sclk1), .ss(ss1), .mosi(mosi1), .miso(mosi1), .bus(bus1));

  // Behavioural slave on the CLK_DIV=4 instance: preload/shift on falling sclk, capture mosi at rising sclk
  logic [31:0] slv_preload = 32'h0;
  logic [31:0] slv_tx      = 32'h0;
  logic [31:0] slv_rx      = 32'h0;
  logic [31:0] slv_word    = 32'h0;
  int          slv_cnt     = 0;
  int          slv_irq_cnt = 0;
  int          irq_cnt4    = 0;
  int          ss_hi       = 0;
  int          last_gap    = 0;
  int          p1_cnt      = 0;
  int          p1_last     = 0;
  logic        prev_sclk4  = 1'b0;
  logic        prev_mosi4  = 1'b0;
  logic        prev_ss4    = 1'b1;
  logic        prev_sclk1  = 1'b0;

  assign miso4 = use_slave ? slv_tx[0] : mosi4;

  always @(negedge sclk4) slv_tx <= (ss4 === 1'b1) ? slv_preload : (slv_tx >> 1);

  always @(posedge clk) begin
    if (sclk4 === 1'b1 && !prev_sclk4 && ss4 === 1'b0) begin
      slv_rx  <= {prev_mosi4, slv_rx[31:1]};
      slv_cnt <= slv_cnt + 1;
    end
    if (ss4 === 1'b1 && !prev_ss4) begin
      if (slv_cnt == 32) begin
        slv_word    <= slv_rx;
        slv_irq_cnt <= slv_irq_cnt + 1;
      end
      slv_cnt <= 0;
    end
    if (bus4.interrupt === 1'b1) irq_cnt4 <= irq_cnt4 + 1;
    if (ss4 === 1'b1) ss_hi <= ss_hi + 1;
    else begin
      if (ss_hi != 0) last_gap <= ss_hi;
      ss_hi <= 0;
    end
    p1_cnt <= p1_cnt + 1;
    if (sclk1 === 1'b1 && !prev_sclk1) begin
      p1_last <= p1_cnt;
      p1_cnt  <= 1;
    end
    prev_sclk4 <= (sclk4 === 1'b1);
    prev_mosi4 <= (mosi4 === 1'b1);
    prev_ss4   <= (ss4 !== 1'b0);
    prev_sclk1 <= (sclk1 === 1'b1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input bit which, input logic [31:0] data);
    @(negedge clk);
    if (which) begin bus1.sel = 1'b1; bus1.we = 1'b1; bus1.address = A_TX; bus1.data_in = data; end
    else       begin bus4.sel = 1'b1; bus4.we = 1'b1; bus4.address = A_TX; bus4.data_in = data; end
    @(negedge clk);
    if (which) begin bus1.sel = 1'b0; bus1.we = 1'b0; bus1.address = A_RX; end
    else       begin bus4.sel = 1'b0; bus4.we = 1'b0; bus4.address = A_RX; end
  endtask

  task automatic bus_read(input bit which, input logic [3:0] addr, output logic [31:0] val);
    if (which) bus1.address = addr; else bus4.address = addr;
    #1;
    val = which ? bus1.data_out : bus4.data_out;
  endtask

  // Counts posedges until the interrupt shows; rx_before is SPI_RX as read in the cycle before it
  task automatic wait_irq(input bit which, output int cyc,
                          output logic [31:0] rx_before, output logic [31:0] rx_after);
    cyc       = -1;
    rx_before = 32'hDEAD_DEAD;
    rx_after  = 32'hDEAD_DEAD;
    if (which) bus1.address = A_RX; else bus4.address = A_RX;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk);
      #1;
      if ((which ? bus1.interrupt : bus4.interrupt) === 1'b1) begin
        cyc      = n;
        rx_after = which ? bus1.data_out : bus4.data_out;
        break;
      end
      rx_before = which ? bus1.data_out : bus4.data_out;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v, rb, ra;
    int          cyc, k;
    bus4.sel = 1'b0; bus4.we = 1'b0; bus4.address = A_RX; bus4.data_in = '0;
    bus1.sel = 1'b0; bus1.we = 1'b0; bus1.address = A_RX; bus1.data_in = '0;
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(sclk4), 32'd0);
    chk("rst_ss",   32'(ss4),   32'd1);
    chk("rst_ss1",  32'(ss1),   32'd1);
    chk("rst_mosi", 32'(mosi4), 32'd0);
    chk("rst_irq",  32'(bus4.interrupt), 32'd0);
    bus_read(0, A_READY, v); chk("rst_ready", v, 32'd1);
    bus_read(0, A_RX, v);    chk("rst_rx", v, 32'd0);
    @(negedge clk) rst = 1'b1;

    // Reset in the middle of SHIFT, while sclk is high
    bus_write(0, 32'h5A5A_5A5A);
    repeat (61) @(negedge clk);
    chk("mid_sclk", 32'(sclk4), 32'd1);
    chk("mid_ss",   32'(ss4),   32'd0);
    bus_read(0, A_READY, v); chk("mid_ready", v, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_sclk", 32'(sclk4), 32'd0);
    chk("abort_ss",   32'(ss4),   32'd1);
    chk("abort_mosi", 32'(mosi4), 32'd0);
    chk("abort_irq",  32'(bus4.interrupt), 32'd0);
    bus_read(0, A_READY, v); chk("abort_ready", v, 32'd1);
    bus_read(0, A_RX, v);    chk("abort_rx", v, 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (300) @(negedge clk);
    chk("abort_no_irq", 32'(irq_cnt4), 32'd0);

    // Loopback, CLK_DIV=4
    use_slave = 1'b0;
    bus_write(0, 32'hA5C3_0F81);
    wait_irq(0, cyc, rb, ra);
    chk("lb_latency", 32'(cyc), 32'd280);
    chk("lb_rx_old",  rb, 32'h0);
    chk("lb_rx",      ra, 32'hA5C3_0F81);
    chk("lb_mosi_order", slv_word, 32'hA5C3_0F81);
    @(posedge clk); #1;
    chk("lb_irq_pulse", 32'(bus4.interrupt), 32'd0);
    chk("lb_irq_count", 32'(irq_cnt4), 32'd1);
    bus_read(0, A_READY, v); chk("lb_ready", v, 32'd1);
    bus_read(0, A_TX, v);    chk("tx_reads_zero", v, 32'd0);

    // Against the behavioural slave
    use_slave   = 1'b1;
    slv_preload = 32'h1234_5678;
    k = slv_irq_cnt;
    bus_write(0, 32'hDEAD_BEEF);
    wait_irq(0, cyc, rb, ra);
    chk("slv_latency", 32'(cyc), 32'd280);
    chk("slv_master_rx", ra, 32'h1234_5678);
    chk("slv_rx", slv_word, 32'hDEAD_BEEF);
    chk("slv_irq", 32'(slv_irq_cnt), 32'(k + 1));

    // Write while busy is ignored
    use_slave = 1'b0;
    bus_write(0, 32'h1111_1111);
    repeat (9) @(negedge clk);
    bus_write(0, 32'h2222_2222);
    bus_read(0, A_READY, v); chk("busy_ready", v, 32'd0);
    wait_irq(0, cyc, rb, ra);
    chk("busy_latency", 32'(cyc), 32'd269);
    chk("busy_rx", ra, 32'h1111_1111);
    chk("busy_mosi", slv_word, 32'h1111_1111);
    bus_read(0, A_READY, v); chk("busy_ready_done", v, 32'd1);

    // CLK_DIV=1 loopback
    bus_write(1, 32'hFFFF_0000);
    wait_irq(1, cyc, rb, ra);
    chk("div1_latency", 32'(cyc), 32'd70);
    chk("div1_rx", ra, 32'hFFFF_0000);
    chk("div1_sclk_period", 32'(p1_last), 32'd2);

    // Back-to-back: next write in the cycle READY rises
    bus_write(0, 32'h0F0F_1234);
    wait_irq(0, cyc, rb, ra);
    chk("b2b_latency1", 32'(cyc), 32'd280);
    chk("b2b_rx1", ra, 32'h0F0F_1234);
    bus4.sel = 1'b1; bus4.we = 1'b1; bus4.address = A_TX; bus4.data_in = 32'hC0DE_5A3C;
    @(posedge clk); #1;
    bus4.sel = 1'b0; bus4.we = 1'b0;
    wait_irq(0, cyc, rb, ra);
    chk("b2b_latency2", 32'(cyc), 32'd280);
    chk("b2b_rx_old", rb, 32'h0F0F_1234);
    chk("b2b_rx2", ra, 32'hC0DE_5A3C);
    chk("b2b_ss_gap", 32'(last_gap), 32'd17);
    chk("b2b_mosi", slv_word, 32'hC0DE_5A3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
